ptp_readout_ctrl: RTL and testbench

Sequencing controller for the Manchester Baby state readout path. On a host request it freezes the Baby, snapshots up to five 32-bit state words (RAM data, address, accumulator, CI, PI), and streams them byte-by-byte over an 8-bit valid/ready port toward the TinyTapeout output pins. It then releases the Baby. It sits between the Baby core and the pin mux and replaces free-running strobe-driven serialisation with an explicit, host-paced dump.

---
 rtl/ptp_pkg.sv | 22 ++
 rtl/ptp_readout_ctrl_if.sv | 12 +
 rtl/ptp_mask_next.sv | 25 ++
 rtl/ptp_readout_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_ptp_readout_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ptp_pkg.sv
// Shared ptp package: readout FSM states, default snapshot geometry and byte helpers.
package ptp_pkg;

  localparam int unsigned PTP_NUM_WORDS  = 5;
  localparam int unsigned PTP_WORD_W     = 32;
  localparam int unsigned PTP_BYTE_W     = 8;
  localparam int unsigned BYTES_PER_WORD = PTP_WORD_W / PTP_BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } readout_state_e;

  // Byte count for a non-default word width.
  function automatic int unsigned bytes_per_word(input int unsigned word_w);
    return word_w / PTP_BYTE_W;
  endfunction

endpackage

// File: rtl/ptp_readout_ctrl_if.sv
// Byte-stream valid/ready port from the readout controller toward the pin mux.
interface ptp_readout_ctrl_if;
  import ptp_pkg::*;

  logic [PTP_BYTE_W-1:0] byte_o;
  logic                  byte_valid_o;
  logic                  byte_ready_i;

  modport master (output byte_o, output byte_valid_o, input byte_ready_i);
  modport slave  (input byte_o, input byte_valid_o, output byte_ready_i);

endinterface

// File: rtl/ptp_mask_next.sv
// Finds the lowest set mask bit at or above i_from; o_none_c flags that none remain.
module ptp_mask_next #(
  parameter int unsigned N      = 5,
  parameter int unsigned FROM_W = 3,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [N-1:0]      i_mask,
  input  logic [FROM_W-1:0] i_from,
  output logic [IDX_W-1:0]  o_idx_c,
  output logic              o_none_c
);

  // Descending scan so the lowest qualifying bit is the one left standing.
  always_comb begin
    o_idx_c  = '0;
    o_none_c = 1'b1;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (i_mask[k] && (k >= int'(i_from))) begin
        o_idx_c  = IDX_W'(k);
        o_none_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ptp_readout_ctrl.sv
// Host-paced Baby state dump: halt, snapshot masked words, stream bytes MSB first, release.
// Optional PTP_READOUT_CHECKSUM_EN appends an XOR checksum byte after the data bytes.
module ptp_readout_ctrl
  import ptp_pkg::*;
#(
  parameter int unsigned NUM_WORDS = PTP_NUM_WORDS,
  parameter int unsigned WORD_W    = PTP_WORD_W
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [NUM_WORDS-1:0]        word_mask_i,
  input  logic [NUM_WORDS*WORD_W-1:0] words_i,
  output logic                        halt_req_o,
  input  logic                        halt_ack_i,
  ptp_readout_ctrl_if.master          bus,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned L_BPW  = bytes_per_word(WORD_W);
  localparam int unsigned WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned SIDX_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned BIDX_W = (L_BPW > 1) ? $clog2(L_BPW) : 1;

  readout_state_e          r_state, w_state_nxt;
  logic [NUM_WORDS-1:0]    r_mask, w_mask_nxt;
  logic [WORD_W-1:0]       r_snap [NUM_WORDS];
  logic [WIDX_W-1:0]       r_word_idx, w_word_idx_nxt;
  logic [BIDX_W-1:0]       r_byte_idx, w_byte_idx_nxt;
  logic [PTP_BYTE_W-1:0]   r_byte, w_byte_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_halt_req, w_halt_req_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_busy, w_busy_nxt;

  logic [WORD_W-1:0]       w_words [NUM_WORDS];
  logic [SIDX_W-1:0]       w_from;
  logic [WIDX_W-1:0]       w_next_idx;
  logic                    w_none;
  logic                    w_xfer;
  logic                    w_last_byte;

`ifdef PTP_READOUT_CHECKSUM_EN
  logic [PTP_BYTE_W-1:0]   r_cks, w_cks_nxt;
  logic                    r_cks_phase, w_cks_phase_nxt;
`endif

  // Byte k of a word, counting from the MSB end.
  function automatic logic [PTP_BYTE_W-1:0] f_byte(input logic [WORD_W-1:0] w,
                                                   input logic [BIDX_W-1:0] k);
    logic [WORD_W-1:0] s;
    s = w << (32'(k) * 32'(PTP_BYTE_W));
    return s[WORD_W-1 -: PTP_BYTE_W];
  endfunction

  always_comb begin
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      w_words[k] = words_i[(int'(NUM_WORDS) - k) * int'(WORD_W) - 1 -: WORD_W];
    end
  end

  assign w_from      = (r_state == ST_CAPTURE) ? '0 : SIDX_W'(r_word_idx) + SIDX_W'(1);
  assign w_xfer      = r_valid && bus.byte_ready_i;
  assign w_last_byte = (r_byte_idx == BIDX_W'(L_BPW - 1));

  ptp_mask_next #(
    .N      (NUM_WORDS),
    .FROM_W (SIDX_W),
    .IDX_W  (WIDX_W)
  ) u_mask_next (
    .i_mask   (r_mask),
    .i_from   (w_from),
    .o_idx_c  (w_next_idx),
    .o_none_c (w_none)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_halt_req <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_byte     <= w_byte_nxt;
      r_valid    <= w_valid_nxt;
      r_halt_req <= w_halt_req_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Snapshot only loads in CAPTURE so words_i may move freely while streaming.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < int'(NUM_WORDS); k++) r_snap[k] <= '0;
    end else if (r_state == ST_CAPTURE) begin
      for (int k = 0; k < int'(NUM_WORDS); k++) r_snap[k] <= w_words[k];
    end
  end

`ifdef PTP_READOUT_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cks       <= '0;
      r_cks_phase <= 1'b0;
    end else begin
      r_cks       <= w_cks_nxt;
      r_cks_phase <= w_cks_phase_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_mask_nxt      = r_mask;
    w_word_idx_nxt  = r_word_idx;
    w_byte_idx_nxt  = r_byte_idx;
    w_byte_nxt      = r_byte;
    w_valid_nxt     = r_valid;
    w_halt_req_nxt  = r_halt_req;
    w_done_nxt      = 1'b0;
`ifdef PTP_READOUT_CHECKSUM_EN
    w_cks_nxt       = r_cks;
    w_cks_phase_nxt = r_cks_phase;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_mask_nxt = word_mask_i;
          if (word_mask_i == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt    = ST_HALT;
            w_halt_req_nxt = 1'b1;
          end
        end
      end

      ST_HALT: begin
        if (abort_i) begin
          w_state_nxt    = ST_IDLE;
          w_halt_req_nxt = 1'b0;
          w_valid_nxt    = 1'b0;
          w_byte_nxt     = '0;
        end else if (halt_ack_i) begin
          w_state_nxt = ST_CAPTURE;
        end
      end

      // First byte comes straight from words_i, the same value the snapshot takes.
      ST_CAPTURE: begin
        if (abort_i) begin
          w_state_nxt    = ST_IDLE;
          w_halt_req_nxt = 1'b0;
          w_valid_nxt    = 1'b0;
          w_byte_nxt     = '0;
        end else begin
          w_state_nxt    = ST_SEND;
          w_word_idx_nxt = w_next_idx;
          w_byte_idx_nxt = '0;
          w_byte_nxt     = f_byte(w_words[w_next_idx], '0);
          w_valid_nxt    = 1'b1;
`ifdef PTP_READOUT_CHECKSUM_EN
          w_cks_nxt       = '0;
          w_cks_phase_nxt = 1'b0;
`endif
        end
      end

      ST_SEND: begin
        if (abort_i) begin
          w_state_nxt    = ST_IDLE;
          w_halt_req_nxt = 1'b0;
          w_valid_nxt    = 1'b0;
          w_byte_nxt     = '0;
        end else if (w_xfer) begin
`ifdef PTP_READOUT_CHECKSUM_EN
          w_cks_nxt = r_cks ^ r_byte;
          if (r_cks_phase) begin
            w_state_nxt     = ST_DONE;
            w_valid_nxt     = 1'b0;
            w_halt_req_nxt  = 1'b0;
            w_done_nxt      = 1'b1;
            w_byte_nxt      = '0;
            w_cks_phase_nxt = 1'b0;
          end else if (w_last_byte && w_none) begin
            w_cks_phase_nxt = 1'b1;
            w_byte_nxt      = r_cks ^ r_byte;
          end else
`else
          if (w_last_byte && w_none) begin
            w_state_nxt    = ST_DONE;
            w_valid_nxt    = 1'b0;
            w_halt_req_nxt = 1'b0;
            w_done_nxt     = 1'b1;
            w_byte_nxt     = '0;
          end else
`endif
          if (w_last_byte) begin
            w_word_idx_nxt = w_next_idx;
            w_byte_idx_nxt = '0;
            w_byte_nxt     = f_byte(r_snap[w_next_idx], '0);
          end else begin
            w_byte_idx_nxt = r_byte_idx + BIDX_W'(1);
            w_byte_nxt     = f_byte(r_snap[r_word_idx], r_byte_idx + BIDX_W'(1));
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_halt_req_nxt = 1'b0;
        w_valid_nxt    = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign halt_req_o       = r_halt_req;
  assign bus.byte_o       = r_byte;
  assign bus.byte_valid_o = r_valid;
  assign busy_o           = r_busy;
  assign done_o           = r_done;

endmodule

// File: tb/tb_ptp_readout_ctrl.sv
// Bench for ptp_readout_ctrl: vector table of dumps plus hand-written stall/ack/abort/reset sequences.
module tb_ptp_readout_ctrl;
  import ptp_pkg::*;

  localparam int unsigned NW = 5;
  localparam int unsigned WW = 32;
  localparam logic [NW*WW-1:0] WORDS_A = {32'h11223344, 32'h55667788, 32'h99AABBCC,
                                          32'hDDEEFF00, 32'h0BADF00D};
  localparam logic [NW*WW-1:0] WORDS_B = {32'hCAFEBABE, 32'h01020304, 32'hFFFFFFFF,
                                          32'h12345678, 32'h87654321};
`ifdef PTP_READOUT_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort, halt_ack, halt_req, busy, done;
  logic [NW-1:0]     mask;
  logic [NW*WW-1:0]  words;

  ptp_readout_ctrl_if bif ();

  ptp_readout_ctrl #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .word_mask_i (mask),
    .words_i     (words),
    .halt_req_o  (halt_req),
    .halt_ack_i  (halt_ack),
    .bus         (bif.master),
    .busy_o      (busy),
    .done_o      (done)
  );

  int checks = 0, errors = 0;
  logic [7:0] exp_q [$];
  int xfer_cnt = 0, done_cnt = 0, cyc = 0;
  int first_x = -1, last_x = -1, done_cyc = -1;
  logic [7:0] first_byte, last_byte;
  bit halt_seen;

  typedef struct {
    logic [NW-1:0] mask;
    int            ack_dly;
    bit            rnd;
    int            nbytes;
    logic [7:0]    first_b;
    logic [7:0]    last_b;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard model: masked words in ascending order, MSB byte first, optional XOR tail.
  function automatic void push_exp(input logic [NW-1:0] m, input logic [NW*WW-1:0] w);
    logic [7:0]    x, b;
    logic [WW-1:0] wd;
    x = '0;
    for (int k = 0; k < int'(NW); k++) begin
      if (m[k]) begin
        wd = w[(int'(NW) - k) * int'(WW) - 1 -: WW];
        for (int j = 0; j < 4; j++) begin
          b = wd[int'(WW) - 1 - 8 * j -: 8];
          exp_q.push_back(b);
          x ^= b;
        end
      end
    end
    if (CKS != 0 && m != '0) exp_q.push_back(x);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (halt_req) halt_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bif.byte_valid_o && bif.byte_ready_i) begin
        if (first_x < 0) begin
          first_x    = cyc;
          first_byte = bif.byte_o;
        end
        last_x    = cyc;
        last_byte = bif.byte_o;
        xfer_cnt++;
        chk("halt_req_during_send", int'(halt_req), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte actual=0x%0h required=none (cycle %0d)", bif.byte_o, cyc);
        end else begin
          chk("byte_stream", int'(bif.byte_o), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_dump(input logic [NW-1:0] m);
    push_exp(m, words);
    first_x   = -1;
    halt_seen = 1'b0;
    mask      = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic give_ack(input int dly);
    repeat (dly) tick();
    halt_ack = 1'b1;
    tick();
    halt_ack = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (rnd) bif.byte_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_pulse_count", done_cnt - d0, 1);
    bif.byte_ready_i = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0;
    vt[0] = '{5'b11111, 0, 1'b0, 20, 8'h11, 8'h0D};
    vt[1] = '{5'b10100, 0, 1'b0,  8, 8'h99, 8'h0D};
    vt[2] = '{5'b00001, 3, 1'b1,  4, 8'h11, 8'h44};
    vt[3] = '{5'b01010, 1, 1'b1,  8, 8'h55, 8'h00};
    vt[4] = '{5'b00000, 0, 1'b0,  0, 8'h00, 8'h00};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; halt_ack = 1'b0;
    mask = '0; words = WORDS_A; bif.byte_ready_i = 1'b1;
    repeat (3) tick();
    chk("reset_halt_req", int'(halt_req), 0);
    chk("reset_valid", int'(bif.byte_valid_o), 0);
    chk("reset_byte", int'(bif.byte_o), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      x0 = xfer_cnt;
      begin_dump(vt[i].mask);
      if (vt[i].mask == '0) begin
        chk("zero_mask_done_next_cycle", int'(done), 1);
        chk("zero_mask_halt_low", int'(halt_req), 0);
      end else begin
        chk("halt_req_in_halt", int'(halt_req), 1);
        give_ack(vt[i].ack_dly);
      end
      wait_done(300, vt[i].rnd);
      chk("xfer_count", xfer_cnt - x0, vt[i].nbytes + ((vt[i].mask != '0) ? CKS : 0));
      chk("scoreboard_drained", exp_q.size(), 0);
      if (vt[i].mask != '0) begin
        chk("first_byte", int'(first_byte), int'(vt[i].first_b));
        if (CKS == 0) chk("last_byte", int'(last_byte), int'(vt[i].last_b));
        if (!vt[i].rnd) begin
          chk("no_bubbles", last_x - first_x, vt[i].nbytes + CKS - 1);
          chk("done_after_last_byte", done_cyc - last_x, 1);
        end
      end else begin
        chk("zero_mask_no_halt", int'(halt_seen), 0);
      end
      tick();
      chk("idle_after_done", int'(busy), 0);
    end

    // Stall inside word 1: 0x66 must hold while ready is low.
    words = WORDS_A;
    bif.byte_ready_i = 1'b0;
    x0 = xfer_cnt;
    begin_dump(5'b11111);
    give_ack(0);
    tick();
    chk("stall_first_valid", int'(bif.byte_valid_o), 1);
    chk("stall_first_byte", int'(bif.byte_o), 8'h11);
    bif.byte_ready_i = 1'b1;
    repeat (5) tick();
    bif.byte_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_byte_hold", int'(bif.byte_o), 8'h66);
      chk("stall_valid_hold", int'(bif.byte_valid_o), 1);
      if (s < 2) tick();
    end
    bif.byte_ready_i = 1'b1;
    wait_done(100, 1'b0);
    chk("stall_xfer_count", xfer_cnt - x0, 20 + CKS);
    chk("stall_scoreboard_drained", exp_q.size(), 0);
    tick();

    // Late ack, then words_i changes once the snapshot is taken.
    words = WORDS_A;
    begin_dump(5'b11111);
    repeat (10) tick();
    chk("late_ack_no_valid", int'(bif.byte_valid_o), 0);
    chk("late_ack_halt_req", int'(halt_req), 1);
    halt_ack = 1'b1;
    tick();
    halt_ack = 1'b0;
    chk("capture_cycle_no_valid", int'(bif.byte_valid_o), 0);
    tick();
    chk("valid_two_after_ack", int'(bif.byte_valid_o), 1);
    chk("valid_two_after_ack_byte", int'(bif.byte_o), 8'h11);
    words = WORDS_B;
    wait_done(100, 1'b0);
    chk("late_ack_scoreboard_drained", exp_q.size(), 0);
    words = WORDS_A;
    tick();

    // Abort after three transfers, then a fresh dump restarts from byte 0.
    x0 = xfer_cnt;
    d0 = done_cnt;
    begin_dump(5'b11111);
    give_ack(0);
    for (int i = 0; i < 50 && (xfer_cnt - x0) < 3; i++) tick();
    chk("abort_three_sent", xfer_cnt - x0, 3);
    bif.byte_ready_i = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_halt_req", int'(halt_req), 0);
    chk("abort_valid", int'(bif.byte_valid_o), 0);
    chk("abort_byte", int'(bif.byte_o), 0);
    chk("abort_done", int'(done), 0);
    exp_q.delete();
    bif.byte_ready_i = 1'b1;
    repeat (3) tick();
    chk("abort_no_done_pulse", done_cnt - d0, 0);
    begin_dump(5'b11111);
    give_ack(0);
    wait_done(100, 1'b0);
    chk("restart_first_byte", int'(first_byte), 8'h11);
    chk("restart_scoreboard_drained", exp_q.size(), 0);
    tick();

    // Reset mid-dump drops halt_req asynchronously.
    d0 = done_cnt;
    begin_dump(5'b11111);
    give_ack(0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_halt_req", int'(halt_req), 0);
    chk("reset_mid_busy", int'(busy), 0);
    chk("reset_mid_valid", int'(bif.byte_valid_o), 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    chk("reset_mid_no_done", done_cnt - d0, 0);

`ifdef PTP_READOUT_CHECKSUM_EN
    words = {32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h0};
    x0 = xfer_cnt;
    begin_dump(5'b00001);
    give_ack(0);
    wait_done(100, 1'b0);
    chk("cks_xfer_count", xfer_cnt - x0, 5);
    chk("cks_byte_value", int'(last_byte), 8'h00);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
